// File: rtl/player_pkg.sv
// Shared types and constants for the player/tank controller.
// Holds the FSM state enum, key event encodings and terrain-contact bit indices.
package player_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WALK,
    ST_CLIMB,
    ST_FALL,
    ST_DEAD
  } state_e;

  localparam logic [1:0] EDGE_PRESS = 2'b01;
  localparam logic [1:0] EDGE_HOLD  = 2'b11;
  localparam logic [1:0] EDGE_REL   = 2'b10;

  localparam logic [4:0] KEY_FWD    = 5'b10000;
  localparam logic [4:0] KEY_BACK   = 5'b01000;
  localparam logic [4:0] KEY_UP     = 5'b00100;
  localparam logic [4:0] KEY_DOWN   = 5'b00010;
  localparam logic [4:0] KEY_CANNON = 5'b00001;

  localparam int ENV_UP_BLK    = 3;
  localparam int ENV_SUPP      = 2;
  localparam int ENV_LEFT_BLK  = 1;
  localparam int ENV_RIGHT_BLK = 0;

endpackage

// File: rtl/player_tick_gen.sv
// Free-running motion tick divider: strobes o_tick for one clock every TICK_DIV clocks.
module player_tick_gen #(
  parameter int TICK_DIV = 16
) (
  input  logic clock,
  input  logic rst,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/player_ctrl_v2.sv
// Per-player tank controller: motion FSM, cannon angle/power, health and fire handshake.
// Optional macro PLAYER_GRAVITY_ACCEL_EN makes the fall step accelerate from 1 up to DROP_V.
module player_ctrl_v2
  import player_pkg::*;
#(
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int BOARD_X    = 2047,
  parameter int BOARD_Y    = 1535,
  parameter int INIT_X     = 0,
  parameter int INIT_Y     = 0,
  parameter int SIDE       = 0,
  parameter int WALK_V     = 32,
  parameter int CLIMB_V    = 32,
  parameter int DROP_V     = 48,
  parameter int ANGLE_STEP = 16,
  parameter int ANGLE_MAX  = 90,
  parameter int POWER_STEP = 16,
  parameter int POWER_MAX  = 255,
  parameter int HEALTH_MAX = 255,
  parameter int TICK_DIV   = 16
) (
  input  logic           clock,
  input  logic           rst,
  input  logic           key_valid,
  input  logic [1:0]     key_edge,
  input  logic [4:0]     key_code,
  input  logic [3:0]     env,
  input  logic           hit,
  input  logic [7:0]     damage,
  input  logic           fire_ready,
  output logic [X_W-1:0] obj_x,
  output logic [Y_W-1:0] obj_y,
  output logic           direction,
  output logic [7:0]     angle,
  output logic [7:0]     power,
  output logic [7:0]     health,
  output logic           alive,
  output logic           fire_valid,
  output logic [7:0]     fire_angle,
  output logic [7:0]     fire_power
);

  // Legal range is also capped by what the position registers can hold.
  localparam int X_LIM = (BOARD_X > (1 << X_W) - 1) ? (1 << X_W) - 1 : BOARD_X;
  localparam int Y_LIM = (BOARD_Y > (1 << Y_W) - 1) ? (1 << Y_W) - 1 : BOARD_Y;

  localparam logic [X_W-1:0] WALK_VX     = X_W'(WALK_V);
  localparam logic [Y_W-1:0] CLIMB_VY    = Y_W'(CLIMB_V);
  localparam logic [7:0]     DROP_V8     = 8'(DROP_V);
  localparam logic [7:0]     ANGLE_STEP8 = 8'(ANGLE_STEP);
  localparam logic [7:0]     ANGLE_MAX8  = 8'(ANGLE_MAX);
  localparam logic [7:0]     POWER_STEP8 = 8'(POWER_STEP);
  localparam logic [7:0]     POWER_MAX8  = 8'(POWER_MAX);

  function automatic logic [7:0] sat_add(input logic [7:0] v, input logic [7:0] s,
                                         input logic [7:0] m);
    logic [8:0] t;
    t = {1'b0, v} + {1'b0, s};
    return (t > {1'b0, m}) ? m : t[7:0];
  endfunction

  function automatic logic [7:0] sat_sub(input logic [7:0] v, input logic [7:0] s);
    return (v > s) ? (v - s) : 8'd0;
  endfunction

  state_e         r_state;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           r_dir;
  logic [7:0]     r_angle;
  logic [7:0]     r_power;
  logic [7:0]     r_health;
  logic           r_fire_valid;
  logic [7:0]     r_fire_angle;
  logic [7:0]     r_fire_power;

  logic       w_tick;
  logic       w_press, w_hold, w_rel, w_repeat;
  logic       w_up_blk, w_supp, w_left_blk, w_right_blk, w_face_blk;
  logic       w_walk_go, w_climb_go, w_fall_go, w_oob;
  logic [7:0] w_health_hit;
  logic       w_kill;
  logic       w_fire_done;
  logic [7:0] w_fall_v;

  player_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clock (clock),
    .rst   (rst),
    .o_tick(w_tick)
  );

  assign w_press     = key_valid && (key_edge == EDGE_PRESS);
  assign w_hold      = key_valid && (key_edge == EDGE_HOLD);
  assign w_rel       = key_valid && (key_edge == EDGE_REL);
  assign w_repeat    = w_press || (w_hold && w_tick);
  assign w_up_blk    = env[ENV_UP_BLK];
  assign w_supp      = env[ENV_SUPP];
  assign w_left_blk  = env[ENV_LEFT_BLK];
  assign w_right_blk = env[ENV_RIGHT_BLK];
  assign w_face_blk  = r_dir ? w_right_blk : w_left_blk;

`ifdef PLAYER_GRAVITY_ACCEL_EN
  logic [7:0] r_fall_step;

  // Step restarts at 1 whenever the player is not falling, so FALL entry always sees 1.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_fall_step <= 8'd1;
    end else if (r_state != ST_FALL) begin
      r_fall_step <= 8'd1;
    end else if (w_fall_go && !w_oob) begin
      r_fall_step <= sat_add(r_fall_step, 8'd1, DROP_V8);
    end
  end

  assign w_fall_v = r_fall_step;
`else
  assign w_fall_v = DROP_V8;
`endif

  // A step is only attempted on a tick when the state stays put this cycle.
  assign w_walk_go  = (r_state == ST_WALK) && w_tick && key_valid && !w_rel &&
                      w_supp && !w_face_blk;
  assign w_climb_go = (r_state == ST_CLIMB) && w_tick && !w_up_blk && w_face_blk;
  assign w_fall_go  = (r_state == ST_FALL) && w_tick && !w_supp;

  always_comb begin
    w_oob = 1'b0;
    if (w_walk_go) begin
      w_oob = r_dir ? ((int'(r_x) + WALK_V) > X_LIM) : (int'(r_x) < WALK_V);
    end
    if (w_climb_go) begin
      w_oob = int'(r_y) < CLIMB_V;
    end
    if (w_fall_go) begin
      w_oob = (int'(r_y) + int'(w_fall_v)) > Y_LIM;
    end
  end

  assign w_health_hit = sat_sub(r_health, damage);
  assign w_kill       = hit && (w_health_hit == 8'd0);
  assign w_fire_done  = r_fire_valid && fire_ready;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_x          <= X_W'(INIT_X);
      r_y          <= Y_W'(INIT_Y);
      r_dir        <= 1'(SIDE);
      r_angle      <= '0;
      r_power      <= '0;
      r_health     <= 8'(HEALTH_MAX);
      r_fire_valid <= 1'b0;
      r_fire_angle <= '0;
      r_fire_power <= '0;
    end else if (r_state != ST_DEAD) begin
      if (w_oob || w_kill) begin
        r_health     <= '0;
        r_state      <= ST_DEAD;
        r_fire_valid <= 1'b0;
      end else begin
        if (hit) begin
          r_health <= w_health_hit;
        end
        if (w_fire_done) begin
          r_fire_valid <= 1'b0;
          r_power      <= '0;
        end
        case (r_state)
          ST_IDLE: begin
            if (!w_supp) begin
              r_state <= ST_FALL;
            end else if (w_press && (key_code == KEY_FWD)) begin
              r_dir <= 1'b1;
              if (!w_right_blk) begin
                r_state <= ST_WALK;
              end else if (!w_up_blk) begin
                r_state <= ST_CLIMB;
              end
            end else if (w_press && (key_code == KEY_BACK)) begin
              r_dir <= 1'b0;
              if (!w_left_blk) begin
                r_state <= ST_WALK;
              end else if (!w_up_blk) begin
                r_state <= ST_CLIMB;
              end
            end
            if (w_repeat && (key_code == KEY_UP)) begin
              r_angle <= sat_add(r_angle, ANGLE_STEP8, ANGLE_MAX8);
            end
            if (w_repeat && (key_code == KEY_DOWN)) begin
              r_angle <= sat_sub(r_angle, ANGLE_STEP8);
            end
            // A pending shot locks out charging and re-firing until it is accepted.
            if (!r_fire_valid && (key_code == KEY_CANNON)) begin
              if (w_repeat) begin
                r_power <= sat_add(r_power, POWER_STEP8, POWER_MAX8);
              end else if (w_rel && (r_power != 8'd0)) begin
                r_fire_valid <= 1'b1;
                r_fire_angle <= r_angle;
                r_fire_power <= r_power;
              end
            end
          end
          ST_WALK: begin
            if (!key_valid || w_rel) begin
              r_state <= ST_IDLE;
            end else if (!w_supp) begin
              r_state <= ST_FALL;
            end else if (w_face_blk) begin
              r_state <= w_up_blk ? ST_IDLE : ST_CLIMB;
            end else if (w_tick) begin
              r_x <= r_dir ? (r_x + WALK_VX) : (r_x - WALK_VX);
            end
          end
          ST_CLIMB: begin
            if (w_up_blk || !w_face_blk) begin
              r_state <= ST_IDLE;
            end else if (w_tick) begin
              r_y <= r_y - CLIMB_VY;
            end
          end
          ST_FALL: begin
            if (w_supp) begin
              r_state <= ST_IDLE;
            end else if (w_tick) begin
              r_y <= r_y + Y_W'(w_fall_v);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign obj_x      = r_x;
  assign obj_y      = r_y;
  assign direction  = r_dir;
  assign angle      = r_angle;
  assign power      = r_power;
  assign health     = r_health;
  assign alive      = (r_health != 8'd0);
  assign fire_valid = r_fire_valid;
  assign fire_angle = r_fire_angle;
  assign fire_power = r_fire_power;

endmodule

// File: tb/tb_player_ctrl_v2.sv
// Bench for player_ctrl_v2: directed vector table, hand sequences and a random run
// compared against an integer-arithmetic behavioural model.
module tb_player_ctrl_v2;

  localparam int P_INIT_X = 100;
  localparam int P_INIT_Y = 800;
  localparam int P_SIDE   = 1;
  localparam int TDIV     = 4;
  localparam int WALK_V   = 32;
  localparam int CLIMB_V  = 32;
  localparam int DROP_V   = 48;
  localparam int A_STEP   = 16;
  localparam int A_MAX    = 90;
  localparam int P_STEP   = 16;
  localparam int P_MAX    = 255;
  localparam int XLIM     = 2047;
  localparam int YLIM     = 1023;

  localparam int MD_IDLE = 0, MD_WALK = 1, MD_CLIMB = 2, MD_FALL = 3, MD_DEAD = 4;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [1:0]  key_edge = 2'b00;
  logic [4:0]  key_code = 5'b00000;
  logic [3:0]  env = 4'b0100;
  logic        hit = 1'b0;
  logic [7:0]  damage = 8'd0;
  logic        fire_ready = 1'b0;
  logic [10:0] obj_x;
  logic [9:0]  obj_y;
  logic        direction;
  logic [7:0]  angle, power, health;
  logic        alive, fire_valid;
  logic [7:0]  fire_angle, fire_power;

  int n_checks = 0;
  int n_errors = 0;

  player_ctrl_v2 #(
    .INIT_X(P_INIT_X), .INIT_Y(P_INIT_Y), .SIDE(P_SIDE), .TICK_DIV(TDIV)
  ) dut (
    .clock(clock), .rst(rst), .key_valid(key_valid), .key_edge(key_edge),
    .key_code(key_code), .env(env), .hit(hit), .damage(damage), .fire_ready(fire_ready),
    .obj_x(obj_x), .obj_y(obj_y), .direction(direction), .angle(angle), .power(power),
    .health(health), .alive(alive), .fire_valid(fire_valid), .fire_angle(fire_angle),
    .fire_power(fire_power)
  );

  initial forever #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_mode, m_x, m_y, m_dir, m_angle, m_power, m_health, m_fv, m_fa, m_fp, m_cyc, m_fall;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    m_mode = MD_IDLE; m_x = P_INIT_X; m_y = P_INIT_Y; m_dir = P_SIDE;
    m_angle = 0; m_power = 0; m_health = 255; m_fv = 0; m_fa = 0; m_fp = 0;
    m_cyc = 0; m_fall = 1;
  endtask

  task automatic model_step();
    bit tick, press, hold, rel, rep, up_b, sup, l_b, r_b, f_b, moved;
    int nx, ny, nh, fall_v, old_fv;
    if (rst) begin
      model_reset();
      return;
    end
    tick = (m_cyc % TDIV) == (TDIV - 1);
    m_cyc++;
    if (m_mode == MD_DEAD) return;
    press = key_valid && key_edge == 2'b01;
    hold  = key_valid && key_edge == 2'b11;
    rel   = key_valid && key_edge == 2'b10;
    rep   = press || (hold && tick);
    up_b = env[3]; sup = env[2]; l_b = env[1]; r_b = env[0];
    f_b = (m_dir == 1) ? r_b : l_b;
`ifdef PLAYER_GRAVITY_ACCEL_EN
    fall_v = m_fall;
`else
    fall_v = DROP_V;
`endif
    nx = m_x; ny = m_y; moved = 0;
    if (tick && m_mode == MD_WALK && key_valid && !rel && sup && !f_b) begin
      moved = 1; nx = m_x + ((m_dir == 1) ? WALK_V : -WALK_V);
    end
    if (tick && m_mode == MD_CLIMB && !up_b && f_b) begin
      moved = 1; ny = m_y - CLIMB_V;
    end
    if (tick && m_mode == MD_FALL && !sup) begin
      moved = 1; ny = m_y + fall_v;
    end
    nh = hit ? imax(0, m_health - int'(damage)) : m_health;
    if (nx < 0 || nx > XLIM || ny < 0 || ny > YLIM || nh == 0) begin
      m_health = 0; m_mode = MD_DEAD; m_fv = 0;
      return;
    end
    m_health = nh; m_x = nx; m_y = ny;
    if (m_mode != MD_FALL) m_fall = 1;
    else if (moved) m_fall = imin(m_fall + 1, DROP_V);
    old_fv = m_fv;
    if (m_fv == 1 && fire_ready) begin
      m_fv = 0; m_power = 0;
    end
    case (m_mode)
      MD_IDLE: begin
        if (!sup) m_mode = MD_FALL;
        else if (press && key_code == 5'b10000) begin
          m_dir = 1;
          if (!r_b) m_mode = MD_WALK; else if (!up_b) m_mode = MD_CLIMB;
        end else if (press && key_code == 5'b01000) begin
          m_dir = 0;
          if (!l_b) m_mode = MD_WALK; else if (!up_b) m_mode = MD_CLIMB;
        end
        if (rep && key_code == 5'b00100) m_angle = imin(m_angle + A_STEP, A_MAX);
        if (rep && key_code == 5'b00010) m_angle = imax(m_angle - A_STEP, 0);
        if (old_fv == 0 && key_code == 5'b00001) begin
          if (rep) m_power = imin(m_power + P_STEP, P_MAX);
          else if (rel && m_power != 0) begin
            m_fv = 1; m_fa = m_angle; m_fp = m_power;
          end
        end
      end
      MD_WALK: begin
        if (!key_valid || rel) m_mode = MD_IDLE;
        else if (!sup) m_mode = MD_FALL;
        else if (f_b) m_mode = up_b ? MD_IDLE : MD_CLIMB;
      end
      MD_CLIMB: if (up_b || !f_b) m_mode = MD_IDLE;
      MD_FALL:  if (sup) m_mode = MD_IDLE;
      default: ;
    endcase
  endtask

  always @(posedge clock) model_step();

  task automatic cmp_model();
    check("rnd_x", int'(obj_x), m_x);
    check("rnd_y", int'(obj_y), m_y);
    check("rnd_dir", int'(direction), m_dir);
    check("rnd_angle", int'(angle), m_angle);
    check("rnd_power", int'(power), m_power);
    check("rnd_health", int'(health), m_health);
    check("rnd_alive", int'(alive), int'(m_health != 0));
    check("rnd_fire_valid", int'(fire_valid), m_fv);
    check("rnd_fire_angle", int'(fire_angle), m_fa);
    check("rnd_fire_power", int'(fire_power), m_fp);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic kv, input logic [1:0] ke, input logic [4:0] kc,
                       input logic [3:0] ev, input logic h, input logic [7:0] d,
                       input logic fr);
    key_valid = kv; key_edge = ke; key_code = kc; env = ev;
    hit = h; damage = d; fire_ready = fr;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 2'b00, 5'b0, 4'b0100, 1'b0, 8'd0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic kv; logic [1:0] ke; logic [4:0] kc; logic [3:0] ev;
    logic h; logic [7:0] dmg; logic fr; int reps;
    int ex; int edir; int eang; int epow; int ehp; int efv; int efa; int efp;
  } vec_t;

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{1'b1, 2'b01, 5'b10000, 4'b0100, 1'b0, 8'd0,   1'b0, 1,  100, 1, 0,  0,  255, 0, 0,  0};
    vecs[1]  = '{1'b1, 2'b11, 5'b10000, 4'b0100, 1'b0, 8'd0,   1'b0, 11, 196, 1, 0,  0,  255, 0, 0,  0};
    vecs[2]  = '{1'b1, 2'b10, 5'b10000, 4'b0100, 1'b0, 8'd0,   1'b0, 1,  196, 1, 0,  0,  255, 0, 0,  0};
    vecs[3]  = '{1'b1, 2'b01, 5'b00100, 4'b0100, 1'b0, 8'd0,   1'b0, 1,  196, 1, 16, 0,  255, 0, 0,  0};
    vecs[4]  = '{1'b1, 2'b11, 5'b00100, 4'b0100, 1'b0, 8'd0,   1'b0, 6,  196, 1, 48, 0,  255, 0, 0,  0};
    vecs[5]  = '{1'b1, 2'b11, 5'b00100, 4'b0100, 1'b0, 8'd0,   1'b0, 12, 196, 1, 90, 0,  255, 0, 0,  0};
    vecs[6]  = '{1'b1, 2'b01, 5'b00010, 4'b0100, 1'b0, 8'd0,   1'b0, 1,  196, 1, 74, 0,  255, 0, 0,  0};
    vecs[7]  = '{1'b0, 2'b00, 5'b00000, 4'b0100, 1'b0, 8'd0,   1'b0, 3,  196, 1, 74, 0,  255, 0, 0,  0};
    vecs[8]  = '{1'b1, 2'b01, 5'b00001, 4'b0100, 1'b0, 8'd0,   1'b0, 1,  196, 1, 74, 16, 255, 0, 0,  0};
    vecs[9]  = '{1'b1, 2'b11, 5'b00001, 4'b0100, 1'b0, 8'd0,   1'b0, 4,  196, 1, 74, 32, 255, 0, 0,  0};
    vecs[10] = '{1'b1, 2'b10, 5'b00001, 4'b0100, 1'b0, 8'd0,   1'b0, 1,  196, 1, 74, 32, 255, 1, 74, 32};
    vecs[11] = '{1'b0, 2'b00, 5'b00000, 4'b0100, 1'b0, 8'd0,   1'b0, 3,  196, 1, 74, 32, 255, 1, 74, 32};
    vecs[12] = '{1'b1, 2'b01, 5'b00001, 4'b0100, 1'b0, 8'd0,   1'b0, 1,  196, 1, 74, 32, 255, 1, 74, 32};
    vecs[13] = '{1'b0, 2'b00, 5'b00000, 4'b0100, 1'b1, 8'd32,  1'b1, 1,  196, 1, 74, 0,  223, 0, 74, 32};
    vecs[14] = '{1'b0, 2'b00, 5'b00000, 4'b0100, 1'b1, 8'd200, 1'b0, 1,  196, 1, 74, 0,  23,  0, 74, 32};
    vecs[15] = '{1'b0, 2'b00, 5'b00000, 4'b0100, 1'b1, 8'd32,  1'b0, 1,  196, 1, 74, 0,  0,   0, 74, 32};
    vecs[16] = '{1'b1, 2'b01, 5'b01000, 4'b0100, 1'b0, 8'd0,   1'b0, 1,  196, 1, 74, 0,  0,   0, 74, 32};
    vecs[17] = '{1'b1, 2'b01, 5'b00100, 4'b0100, 1'b0, 8'd0,   1'b0, 1,  196, 1, 74, 0,  0,   0, 74, 32};

    do_reset();
    check("reset_x", int'(obj_x), 100);
    check("reset_y", int'(obj_y), 800);
    check("reset_dir", int'(direction), 1);
    check("reset_angle", int'(angle), 0);
    check("reset_power", int'(power), 0);
    check("reset_health", int'(health), 255);
    check("reset_alive", int'(alive), 1);
    check("reset_fire_valid", int'(fire_valid), 0);
    check("reset_fire_angle", int'(fire_angle), 0);
    check("reset_fire_power", int'(fire_power), 0);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].kv, vecs[i].ke, vecs[i].kc, vecs[i].ev, vecs[i].h, vecs[i].dmg, vecs[i].fr);
      cycles(vecs[i].reps);
      check($sformatf("vec%0d_x", i), int'(obj_x), vecs[i].ex);
      check($sformatf("vec%0d_dir", i), int'(direction), vecs[i].edir);
      check($sformatf("vec%0d_angle", i), int'(angle), vecs[i].eang);
      check($sformatf("vec%0d_power", i), int'(power), vecs[i].epow);
      check($sformatf("vec%0d_health", i), int'(health), vecs[i].ehp);
      check($sformatf("vec%0d_alive", i), int'(alive), int'(vecs[i].ehp != 0));
      check($sformatf("vec%0d_fire_valid", i), int'(fire_valid), vecs[i].efv);
      check($sformatf("vec%0d_fire_angle", i), int'(fire_angle), vecs[i].efa);
      check($sformatf("vec%0d_fire_power", i), int'(fire_power), vecs[i].efp);
    end

    // Walk left off the board edge: 100 -> 68 -> 36 -> 4, next step would go negative.
    do_reset();
    drive(1'b1, 2'b01, 5'b01000, 4'b0100, 1'b0, 8'd0, 1'b0);
    cycles(1);
    check("oob_dir", int'(direction), 0);
    drive(1'b1, 2'b11, 5'b01000, 4'b0100, 1'b0, 8'd0, 1'b0);
    cycles(11);
    check("oob_x_before", int'(obj_x), 4);
    check("oob_health_before", int'(health), 255);
    cycles(4);
    check("oob_x_held", int'(obj_x), 4);
    check("oob_health", int'(health), 0);
    check("oob_alive", int'(alive), 0);
    drive(1'b1, 2'b01, 5'b10000, 4'b0100, 1'b0, 8'd0, 1'b0);
    cycles(8);
    check("oob_dead_x", int'(obj_x), 4);
    check("oob_dead_dir", int'(direction), 0);

    // Climb a right-side wall, crest, then fall with no support.
    do_reset();
    drive(1'b1, 2'b01, 5'b10000, 4'b0101, 1'b0, 8'd0, 1'b0);
    cycles(1);
    drive(1'b0, 2'b00, 5'b00000, 4'b0101, 1'b0, 8'd0, 1'b0);
    cycles(7);
    check("climb_y", int'(obj_y), 736);
    check("climb_x", int'(obj_x), 100);
    drive(1'b0, 2'b00, 5'b00000, 4'b0100, 1'b0, 8'd0, 1'b0);
    cycles(1);
    drive(1'b0, 2'b00, 5'b00000, 4'b0000, 1'b0, 8'd0, 1'b0);
    cycles(7);
`ifdef PLAYER_GRAVITY_ACCEL_EN
    check("fall_y", int'(obj_y), 739);
`else
    check("fall_y", int'(obj_y), 832);
`endif
    drive(1'b0, 2'b00, 5'b00000, 4'b0100, 1'b0, 8'd0, 1'b0);
    cycles(8);
`ifdef PLAYER_GRAVITY_ACCEL_EN
    check("land_y", int'(obj_y), 739);
`else
    check("land_y", int'(obj_y), 832);
`endif

    // Random run against the model, with occasional resets mid-activity.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      logic [1:0] edges[4];
      edges[0] = 2'b01; edges[1] = 2'b11; edges[2] = 2'b10; edges[3] = 2'b00;
      rst        = ($urandom_range(0, 149) == 0);
      key_valid  = ($urandom_range(0, 3) != 0);
      key_edge   = ($urandom_range(0, 9) == 0) ? edges[3] : edges[$urandom_range(0, 2)];
      key_code   = ($urandom_range(0, 15) == 0) ? 5'b00000 : 5'(1 << $urandom_range(0, 4));
      env        = {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) != 0),
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)};
      hit        = ($urandom_range(0, 49) == 0);
      damage     = 8'($urandom_range(0, 63));
      fire_ready = ($urandom_range(0, 3) == 0);
      cycles(1);
      cmp_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
